// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared defaults, bit-order enum and length-width helper for the UART RX path
package uart_rx_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int EDGE_CNT_W_DEF = 3;
  localparam int SAMPLE_EDGE_DEF = 6;
  typedef enum logic {LSB_FIRST = 1'b0, MSB_FIRST = 1'b1} bit_order_e;
  function automatic int len_w(input int dw);
    return $clog2(dw + 1);
  endfunction
endpackage

// File: rtl/deser_bit_ctr.sv
// deser_bit_ctr: bit index, latched frame length and last-bit strobe for the deserializer
module deser_bit_ctr import uart_rx_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_W = len_w(DATA_WIDTH),
  parameter int IDX_W = $clog2(DATA_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_clr,
  input  logic             cap,
  input  logic [LEN_W-1:0] cfg_len,
  output logic [IDX_W-1:0] bit_idx,
  output logic [LEN_W-1:0] len_cur,
  output logic             last_bit
);
  logic [LEN_W-1:0] len_q, cfg_s;
  // The first bit of a frame uses the live length; later bits use the latched one.
  always_comb begin
    cfg_s = (cfg_len == '0 || cfg_len > LEN_W'(DATA_WIDTH)) ? LEN_W'(DATA_WIDTH) : cfg_len;
    len_cur = (bit_idx == '0) ? cfg_s : len_q;
    last_bit = cap && (LEN_W'(bit_idx) == len_cur - LEN_W'(1));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bit_idx <= '0;
      len_q <= '0;
    end else if (frame_clr) begin
      bit_idx <= '0;
    end else if (cap) begin
      if (bit_idx == '0) len_q <= cfg_s;
      bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
    end
endmodule

// File: rtl/uart_rx_deserializer_p.sv
// uart_rx_deserializer_p: captures sampled bits into a word and publishes it with a done pulse
module uart_rx_deserializer_p import uart_rx_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int EDGE_CNT_W = EDGE_CNT_W_DEF,
  parameter int SAMPLE_EDGE = SAMPLE_EDGE_DEF,
  parameter bit MSB_FIRST = 1'b0,
  localparam int LEN_W = len_w(DATA_WIDTH),
  localparam int IDX_W = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  deser_en,
  input  logic                  frame_clr,
  input  logic [EDGE_CNT_W-1:0] edge_cnt,
  input  logic                  sampled_bit,
  input  logic [LEN_W-1:0]      cfg_len,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  deser_done,
  output logic [IDX_W-1:0]      bit_idx
);
  logic cap, last_bit;
  logic [IDX_W-1:0] pos;
  logic [LEN_W-1:0] len_cur;
  logic [DATA_WIDTH-1:0] asm_q, asm_w;
  assign cap = deser_en && (edge_cnt == EDGE_CNT_W'(SAMPLE_EDGE)) && !frame_clr;
  deser_bit_ctr #(.DATA_WIDTH(DATA_WIDTH), .LEN_W(LEN_W), .IDX_W(IDX_W)) u_ctr (
    .clk(clk), .rst(rst), .frame_clr(frame_clr), .cap(cap), .cfg_len(cfg_len),
    .bit_idx(bit_idx), .len_cur(len_cur), .last_bit(last_bit)
  );
  always_comb begin
    pos = MSB_FIRST ? IDX_W'(len_cur - LEN_W'(1) - LEN_W'(bit_idx)) : bit_idx;
    asm_w = asm_q;
    asm_w[pos] = sampled_bit;
  end
  // The final bit goes straight to P_DATA so the word is published whole.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      asm_q <= '0;
      P_DATA <= '0;
      deser_done <= 1'b0;
    end else begin
      deser_done <= last_bit;
      if (frame_clr) asm_q <= '0;
      else if (last_bit) begin
        asm_q <= '0;
        P_DATA <= asm_w;
      end else if (cap) asm_q <= asm_w;
    end
endmodule
